// File: rtl/slot_reel_sequencer_pkg.sv
// Shared types for the slot reel sequencer.
// Holds the state encoding used by the controller and its observers.
package slot_pkg;

  localparam int SLOT_STATE_W = 3;

  typedef enum logic [SLOT_STATE_W-1:0] {
    SET      = 3'd0,
    RUN      = 3'd1,
    STOPPING = 3'd2,
    STOP     = 3'd3,
    WIN      = 3'd4
  } slot_state_t;

endpackage

// File: rtl/slot_reel_sequencer_edge_sync.sv
// Button conditioner: synchronises an asynchronous level and produces a
// one-cycle pulse on its rising edge.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   d_async  in   button level, asynchronous to clk
//   rise     out  high for one cycle after a synchronised 0->1 transition
module slot_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Resetting to ones means a button held through reset looks like a
  // steady high afterwards, so it cannot fake a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/slot_reel_sequencer.sv
// Slot machine reel sequencer.
// Starts all reels on a start/stop press, stops them one at a time with a
// fixed gap (on a second press or after a run timeout), then waits in STOP
// for a win indication or a clear press.
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous active-high reset
//   start_stop       in   start/stop button level (asynchronous)
//   clear            in   clear button level (asynchronous)
//   win_flag         in   win indication, synchronous to clk
//   state            out  current state encoding
//   reel_run         out  per-reel spin enable, bit 0 stops first
//   reel_stop_pulse  out  one-cycle pulse as the matching reel stops
//   done             out  one-cycle pulse when the last reel stops
module slot_reel_sequencer
  import slot_pkg::*;
#(
  parameter int NUM_REELS        = 3,
  parameter int SYNC_STAGES      = 2,
  parameter int STOP_GAP         = 4,
  parameter int AUTO_STOP_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_stop,
  input  logic                 clear,
  input  logic                 win_flag,
  output slot_state_t          state,
  output logic [NUM_REELS-1:0] reel_run,
  output logic [NUM_REELS-1:0] reel_stop_pulse,
  output logic                 done
);

  localparam int TIMER_W = (AUTO_STOP_CYCLES > 0) ? $clog2(AUTO_STOP_CYCLES + 1) : 1;
  localparam int IDX_W   = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;
  localparam int GAP_W   = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST =
    TIMER_W'((AUTO_STOP_CYCLES > 0) ? AUTO_STOP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_REELS - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(STOP_GAP - 1);
  localparam logic [NUM_REELS-1:0] REEL0    = NUM_REELS'(1);
  localparam bit                   TIMEOUT_EN = (AUTO_STOP_CYCLES != 0);

  logic ss_rise, clear_rise;

  slot_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (start_stop),
    .rise    (ss_rise)
  );

  slot_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (clear),
    .rise    (clear_rise)
  );

  slot_state_t          state_q, state_d;
  logic [NUM_REELS-1:0] reel_run_q, reel_run_d;
  logic [NUM_REELS-1:0] pulse_q, pulse_d;
  logic                 done_q, done_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic                 timeout;
  logic [NUM_REELS-1:0] stop_mask;

  assign timeout   = TIMEOUT_EN && (timer_q == TIMER_LAST);
  assign stop_mask = REEL0 << idx_q;

  always_comb begin
    state_d    = state_q;
    reel_run_d = reel_run_q;
    pulse_d    = '0;
    done_d     = 1'b0;
    timer_d    = timer_q;
    idx_d      = idx_q;
    gap_d      = gap_q;

    // Clear wins over every other event, and abandons a stop sequence
    // silently: no further stop pulses and no done.
    if (clear_rise) begin
      state_d    = SET;
      reel_run_d = '0;
      timer_d    = '0;
      idx_d      = '0;
      gap_d      = '0;
    end else begin
      unique case (state_q)
        SET: begin
          reel_run_d = '0;
          if (ss_rise) begin
            state_d    = RUN;
            reel_run_d = '1;
            timer_d    = '0;
          end
        end
        RUN: begin
          // Saturate rather than wrap so a disabled timeout never re-fires.
          if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
          if (ss_rise || timeout) begin
            reel_run_d = reel_run_q & ~REEL0;
            pulse_d    = REEL0;
            idx_d      = IDX_W'(1);
            gap_d      = '0;
            if (NUM_REELS == 1) begin
              state_d = STOP;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              state_d = STOPPING;
            end
          end
        end
        STOPPING: begin
          if (gap_q == GAP_LAST) begin
            reel_run_d = reel_run_q & ~stop_mask;
            pulse_d    = stop_mask;
            gap_d      = '0;
            if (idx_q == IDX_LAST) begin
              state_d = STOP;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        STOP: begin
          reel_run_d = '0;
          if (win_flag) state_d = WIN;
        end
        WIN: begin
          reel_run_d = '0;
        end
        default: begin
          state_d    = SET;
          reel_run_d = '0;
          timer_d    = '0;
          idx_d      = '0;
          gap_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SET;
      reel_run_q <= '0;
      pulse_q    <= '0;
      done_q     <= 1'b0;
      timer_q    <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      reel_run_q <= reel_run_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
    end
  end

  assign state           = state_q;
  assign reel_run        = reel_run_q;
  assign reel_stop_pulse = pulse_q;
  assign done            = done_q;

endmodule
